// File: rtl/des_undo_log_writer_pkg.sv
// Shared types for the undo-log writer: entry layout, AXI burst constants
// and the record address helper.
package des_undo_log_writer_pkg;

  localparam int UNDO_LOG_ADDR_WIDTH = 32;
  localparam int UNDO_LOG_DATA_WIDTH = 32;

  typedef logic [UNDO_LOG_ADDR_WIDTH-1:0] undo_log_addr_t;
  typedef logic [UNDO_LOG_DATA_WIDTH-1:0] undo_log_data_t;

  typedef struct packed {
    undo_log_data_t data;
    undo_log_addr_t addr;
  } undo_log_entry_t;

  localparam int ENTRY_W = $bits(undo_log_entry_t);

  localparam logic [7:0] AXI_AWLEN  = 8'd1;
  localparam logic [2:0] AXI_AWSIZE = 3'b010;
  localparam logic [3:0] AXI_WSTRB  = 4'b1111;

  // Each record is one 8-byte {addr, data} pair; the address wraps at 32 bits.
  function automatic undo_log_addr_t rec_addr(input undo_log_addr_t base, input int unsigned idx);
    return base + undo_log_addr_t'(idx << 3);
  endfunction

endpackage

// File: rtl/des_undo_log_writer_if.sv
// AXI write-channel bundle (AW, W, B) between the undo-log writer and memory.
interface des_undo_log_writer_if;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic        WVALID;
  logic        WREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        BVALID;
  logic        BREADY;
  logic [1:0]  BRESP;

  modport master (
    output AWVALID, AWADDR, AWLEN, AWSIZE, WVALID, WDATA, WSTRB, WLAST, BREADY,
    input  AWREADY, WREADY, BVALID, BRESP
  );

  modport slave (
    input  AWVALID, AWADDR, AWLEN, AWSIZE, WVALID, WDATA, WSTRB, WLAST, BREADY,
    output AWREADY, WREADY, BVALID, BRESP
  );
endinterface

// File: rtl/des_undo_log_writer_fifo.sv
// Small synchronous FIFO with registered storage; push and pop may share a cycle.
module undo_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  assign dout  = mem[rptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/des_undo_log_writer.sv
// Buffers undo-log entries and writes each as a 2-beat AXI burst
// (addr, then data) into the current task's log region.
module des_undo_log_writer
  import des_undo_log_writer_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int LOG_ENTRIES = 16,
  parameter int CNT_W       = $clog2(LOG_ENTRIES) + 1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  task_start,
  input  logic [31:0]           log_base,
  input  logic [63:0]           undo_log_entry,
  input  logic                  undo_log_entry_ap_vld,
  output logic                  undo_log_entry_ap_rdy,
  des_undo_log_writer_if.master m_axi,
  output logic [CNT_W-1:0]      entry_count,
  output logic                  drained,
  output logic                  overflow,
  output logic                  resp_err
);
  typedef enum logic [2:0] {S_IDLE, S_AW, S_W0, S_W1, S_RESP} state_t;

  state_t          state, state_n;
  undo_log_entry_t head;
  undo_log_addr_t  log_base_q;
  logic [CNT_W-1:0] alloc_cnt;
  logic [ENTRY_W-1:0] fifo_dout;
  logic fifo_full, fifo_empty, fifo_pop, push, start_ok, alloc_full, b_done;

  assign alloc_full = (alloc_cnt == CNT_W'(LOG_ENTRIES));
  // rdy ignores a same-cycle pop so a full FIFO never sees a push.
  assign undo_log_entry_ap_rdy = ~fifo_full & ~alloc_full & ~ap_rst;
  assign push     = undo_log_entry_ap_vld & undo_log_entry_ap_rdy;
  assign drained  = (state == S_IDLE) & fifo_empty;
  assign start_ok = task_start & drained;
  assign b_done   = (state == S_RESP) & m_axi.BVALID;

  undo_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clk   (ap_clk),
    .rst   (ap_rst),
    .push  (push),
    .din   (undo_log_entry),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_n  = state;
    fifo_pop = 1'b0;
    case (state)
      S_IDLE: if (!fifo_empty) begin
        fifo_pop = 1'b1;
        state_n  = S_AW;
      end
      S_AW:    if (m_axi.AWREADY) state_n = S_W0;
      S_W0:    if (m_axi.WREADY)  state_n = S_W1;
      S_W1:    if (m_axi.WREADY)  state_n = S_RESP;
      S_RESP:  if (m_axi.BVALID)  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) state <= S_IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge ap_clk) begin
    if (fifo_pop) head <= undo_log_entry_t'(fifo_dout);
  end

  // A start only lands while drained, so the base is stable for any burst.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      log_base_q  <= '0;
      alloc_cnt   <= '0;
      entry_count <= '0;
      overflow    <= 1'b0;
      resp_err    <= 1'b0;
    end else begin
      if (start_ok) log_base_q <= log_base;
      alloc_cnt   <= (start_ok ? '0 : alloc_cnt) + CNT_W'(push);
      entry_count <= (start_ok ? '0 : entry_count) + CNT_W'(b_done);
      overflow    <= (start_ok ? 1'b0 : overflow) | (undo_log_entry_ap_vld & alloc_full);
      resp_err    <= (start_ok ? 1'b0 : resp_err) | (b_done & (m_axi.BRESP != 2'b00));
    end
  end

  assign m_axi.AWVALID = (state == S_AW);
  assign m_axi.AWADDR  = rec_addr(log_base_q, 32'(entry_count));
  assign m_axi.AWLEN   = AXI_AWLEN;
  assign m_axi.AWSIZE  = AXI_AWSIZE;
  assign m_axi.WVALID  = (state == S_W0) | (state == S_W1);
  assign m_axi.WDATA   = (state == S_W1) ? head.data : head.addr;
  assign m_axi.WSTRB   = AXI_WSTRB;
  assign m_axi.WLAST   = (state == S_W1);
  assign m_axi.BREADY  = (state == S_RESP);
endmodule

// File: tb/tb_des_undo_log_writer.sv
// Directed bench for des_undo_log_writer with a small AXI write-slave model.
module tb_des_undo_log_writer;
  logic        clk = 1'b0;
  logic        rst;
  logic        task_start;
  logic [31:0] log_base;
  logic [63:0] entry;
  logic        vld, rdy;
  logic [4:0]  entry_count;
  logic        drained, overflow, resp_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] aw_q[$];
  logic [31:0] w_q[$];
  logic        wl_q[$];
  int          rec_no  = 0;
  int          err_rec = -1;
  logic        sl_w_hs, sl_wlast, sl_b_hs;

  des_undo_log_writer_if m_axi ();

  des_undo_log_writer dut (
    .ap_clk                (clk),
    .ap_rst                (rst),
    .task_start            (task_start),
    .log_base              (log_base),
    .undo_log_entry        (entry),
    .undo_log_entry_ap_vld (vld),
    .undo_log_entry_ap_rdy (rdy),
    .m_axi                 (m_axi.master),
    .entry_count           (entry_count),
    .drained               (drained),
    .overflow              (overflow),
    .resp_err              (resp_err)
  );

  always #5 clk = ~clk;

  // Slave: samples handshakes mid-low-phase, raises B the cycle after WLAST.
  initial begin
    m_axi.BVALID = 1'b0;
    m_axi.BRESP  = 2'b00;
    forever begin
      @(negedge clk); #3;
      sl_w_hs  = m_axi.WVALID & m_axi.WREADY & ~rst;
      sl_wlast = m_axi.WLAST;
      sl_b_hs  = m_axi.BVALID & m_axi.BREADY & ~rst;
      if (m_axi.AWVALID && m_axi.AWREADY && !rst) aw_q.push_back(m_axi.AWADDR);
      if (sl_w_hs) begin
        w_q.push_back(m_axi.WDATA);
        wl_q.push_back(m_axi.WLAST);
      end
      @(posedge clk); #1;
      if (rst) m_axi.BVALID = 1'b0;
      else begin
        if (sl_b_hs) m_axi.BVALID = 1'b0;
        if (sl_w_hs && sl_wlast) begin
          m_axi.BVALID = 1'b1;
          m_axi.BRESP  = (rec_no == err_rec) ? 2'b10 : 2'b00;
          rec_no++;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk(input int i);
    return {32'hA000_0000 + 32'(i), 32'h0000_0100 + 32'(i * 4)};
  endfunction

  task automatic send(input logic [63:0] e);
    @(negedge clk);
    vld = 1'b1; entry = e;
    #1 chk("send_rdy", rdy, 1);
    @(negedge clk);
    vld = 1'b0;
  endtask

  task automatic wait_count(input int target, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (entry_count == 5'(target)) break;
    end
    chk(tag, entry_count, target);
  endtask

  task automatic start_task(input logic [31:0] base);
    @(negedge clk);
    task_start = 1'b1; log_base = base;
    @(negedge clk);
    task_start = 1'b0;
  endtask

  initial begin
    int sent, ai, wi;
    rst = 1'b1; task_start = 1'b0; log_base = '0; entry = '0; vld = 1'b0;
    m_axi.AWREADY = 1'b1; m_axi.WREADY = 1'b1;
    repeat (2) @(negedge clk);
    #1 chk("rdy_in_reset", rdy, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_drained", drained, 1);
    chk("rst_count", entry_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_valids", {m_axi.AWVALID, m_axi.WVALID, m_axi.BREADY}, 0);
    chk("rst_rdy", rdy, 1);

    // Basic record
    start_task(32'h1000);
    ai = aw_q.size(); wi = w_q.size();
    send({32'h0123_4567, 32'h0000_2040});
    wait_count(1, 30, "basic_count");
    chk("basic_drained", drained, 1);
    chk("basic_awaddr", aw_q[ai], 32'h1000);
    chk("basic_beat0", w_q[wi], 32'h2040);
    chk("basic_wlast0", wl_q[wi], 0);
    chk("basic_beat1", w_q[wi+1], 32'h0123_4567);
    chk("basic_wlast1", wl_q[wi+1], 1);
    chk("awlen", m_axi.AWLEN, 1);
    chk("awsize", m_axi.AWSIZE, 3'b010);
    chk("wstrb", m_axi.WSTRB, 4'hF);

    // Backpressure: 4 in the FIFO plus 1 held by the FSM before rdy drops
    start_task(32'h1000);
    ai = aw_q.size(); wi = w_q.size();
    m_axi.AWREADY = 1'b0; m_axi.WREADY = 1'b0;
    sent = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      vld = (sent < 6); entry = mk(sent);
      #1 if (vld && rdy) sent++;
    end
    chk("bp_accepts", sent, 5);
    chk("bp_rdy_low", rdy, 0);
    chk("bp_awvalid_held", m_axi.AWVALID, 1);
    chk("bp_awaddr_held", m_axi.AWADDR, 32'h1000);
    m_axi.AWREADY = 1'b1; m_axi.WREADY = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      vld = (sent < 6); entry = mk(sent);
      #1 if (vld && rdy) sent++;
      if (entry_count == 5'd6) break;
    end
    vld = 1'b0;
    chk("bp_sent", sent, 6);
    chk("bp_count", entry_count, 6);
    for (int i = 0; i < 6; i++) begin
      chk("bp_awaddr", aw_q[ai+i], 32'h1000 + 32'(8 * i));
      chk("bp_beat_addr", w_q[wi+2*i], 32'h0000_0100 + 32'(i * 4));
      chk("bp_beat_data", w_q[wi+2*i+1], 32'hA000_0000 + 32'(i));
    end

    // Overflow: 17 offered, 16 accepted
    start_task(32'h2000);
    sent = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      vld = (sent < 17); entry = mk(sent);
      #1 if (vld && rdy) sent++;
    end
    chk("ovf_accepts", sent, 16);
    chk("ovf_flag", overflow, 1);
    chk("ovf_rdy_low", rdy, 0);
    chk("ovf_count", entry_count, 16);
    @(negedge clk); vld = 1'b0;
    start_task(32'h3000);
    #1;
    chk("ovf_cleared", overflow, 0);
    chk("ovf_count_cleared", entry_count, 0);

    // Response error on the second record
    err_rec = rec_no + 1;
    ai = aw_q.size();
    send(mk(20));
    wait_count(1, 30, "rerr_count1");
    chk("rerr_clean_first", resp_err, 0);
    send(mk(21));
    wait_count(2, 30, "rerr_count2");
    chk("rerr_set", resp_err, 1);
    send(mk(22));
    wait_count(3, 30, "rerr_count3");
    chk("rerr_sticky", resp_err, 1);
    chk("rerr_awaddr3", aw_q[ai+2], 32'h3010);

    // task_start while busy (stalled in W0) is ignored
    m_axi.WREADY = 1'b0;
    send(mk(23));
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (m_axi.WVALID) break;
    end
    chk("busy_in_w0", {m_axi.WVALID, m_axi.WLAST}, 2'b10);
    chk("busy_not_drained", drained, 0);
    start_task(32'h9000);
    m_axi.WREADY = 1'b1;
    wait_count(4, 30, "busy_count");
    chk("busy_resp_err_kept", resp_err, 1);
    chk("busy_awaddr", aw_q[aw_q.size()-1], 32'h3018);
    send(mk(24));
    wait_count(5, 30, "busy_count5");
    chk("busy_base_kept", aw_q[aw_q.size()-1], 32'h3020);

    // Reset while in W1
    m_axi.WREADY = 1'b0;
    send({32'hDEAD_BEEF, 32'h0000_0ABC});
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (m_axi.WVALID) break;
    end
    @(negedge clk); m_axi.WREADY = 1'b1;
    @(negedge clk); m_axi.WREADY = 1'b0;
    #1;
    chk("w1_wlast", {m_axi.WVALID, m_axi.WLAST}, 2'b11);
    chk("w1_wdata", m_axi.WDATA, 32'hDEAD_BEEF);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #1;
    chk("mrst_valids", {m_axi.AWVALID, m_axi.WVALID, m_axi.BREADY}, 0);
    chk("mrst_drained", drained, 1);
    chk("mrst_count", entry_count, 0);
    chk("mrst_resp_err", resp_err, 0);
    chk("mrst_rdy", rdy, 0);
    @(negedge clk); rst = 1'b0; m_axi.WREADY = 1'b1;
    @(negedge clk); #1;
    chk("post_rst_rdy", rdy, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
